// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for the asynchronous FIFO pointer logic.
//   fifo_depth : number of entries for a given address width (2**addr_w)
//   bin2gray   : binary -> Gray code, valid for the low 'width' bits
//   gray2bin   : Gray -> binary code, MSB-first XOR prefix over 'width' bits
// Both conversions operate on a MaxW-bit container; bits at and above 'width'
// are forced to zero so callers can cast the result down to their own width.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned MaxW = 32;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic logic [MaxW-1:0] width_mask(input int unsigned width);
        logic [MaxW-1:0] m;
        m = '0;
        for (int i = 0; i < MaxW; i++) begin
            if (i < width) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [MaxW-1:0] bin2gray(input logic [MaxW-1:0] bin,
                                                 input int unsigned     width);
        logic [MaxW-1:0] b;
        b = bin & width_mask(width);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MaxW-1:0] gray2bin(input logic [MaxW-1:0] gray,
                                                 input int unsigned     width);
        logic [MaxW-1:0] g;
        logic [MaxW-1:0] b;
        g = gray & width_mask(width);
        b = g;
        // Each binary bit is the XOR of all Gray bits at or above it.
        for (int i = MaxW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// -----------------------------------------------------------------------------
// fifo_gray2bin
// Purely combinational Gray-to-binary converter, shared by the write- and
// read-side FIFO controllers.
//   Width   : pointer width in bits (>= 1)
//   gray_i  : Gray-coded input
//   bin_o   : binary equivalent
// -----------------------------------------------------------------------------
module fifo_gray2bin #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] gray_i,
    output logic [Width-1:0] bin_o
);

    logic [Width-1:0] bin;

    // MSB-first prefix: bin[i] = bin[i+1] ^ gray[i].
    always_comb begin
        bin = gray_i;
        for (int i = int'(Width) - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray_i[i];
        end
    end

    assign bin_o = bin;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller of the asynchronous FIFO (write clock domain).
// Owns the binary/Gray write pointers, drives the memory write port and
// produces registered full / almost-full flags, a fill level and a sticky
// overflow flag from the read pointer already synchronised into w_clk.
//
// Parameters
//   ADDR_W       : memory address width, DEPTH = 2**ADDR_W (ADDR_W >= 2)
//   AFULL_THRESH : level at or above which almost_full asserts (1..DEPTH)
// Ports
//   w_clk, w_rstn : write clock, asynchronous active-low reset
//   w_inc         : write request
//   w_clr_ovf     : clears the sticky overflow flag
//   sync_rd_ptr   : synchronised Gray read pointer
//   w_en, w_addr  : memory write enable (combinational) and address
//   gray_w_ptr    : registered Gray write pointer towards the read domain
//   full          : registered full flag
//   almost_full   : registered, level >= AFULL_THRESH
//   w_level       : registered fill level, 0..DEPTH
//   overflow      : sticky, a write was attempted while full
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic              w_inc,
    input  logic              w_clr_ovf,
    input  logic [ADDR_W:0]   sync_rd_ptr,
    output logic              w_en,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W:0]   gray_w_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   w_level,
    output logic              overflow
);

    localparam int unsigned PtrW  = ADDR_W + 1;
    localparam int unsigned Depth = fifo_depth(ADDR_W);

    // State
    logic [PtrW-1:0] wbin_q, wbin_d;
    logic [PtrW-1:0] gray_q, gray_d;
    logic [PtrW-1:0] level_q, level_d;
    logic            full_q, full_d;
    logic            afull_q, afull_d;
    logic            ovf_q, ovf_d;

    // Combinational
    logic            accept;
    logic [PtrW-1:0] rbin;
    logic [PtrW-1:0] full_cmp;

    fifo_gray2bin #(
        .Width (PtrW)
    ) u_rd_gray2bin (
        .gray_i (sync_rd_ptr),
        .bin_o  (rbin)
    );

    assign accept = w_inc & ~full_q;

    // Full when the write pointer is one lap ahead of the read pointer: in
    // Gray code that means the two MSBs differ and the rest match.
    assign full_cmp = {~sync_rd_ptr[ADDR_W:ADDR_W-1], sync_rd_ptr[ADDR_W-2:0]};

    always_comb begin
        wbin_d  = wbin_q + PtrW'(accept);
        gray_d  = PtrW'(bin2gray(MaxW'(wbin_d), PtrW));
        // Modular difference of two pointers that are at most one lap apart.
        level_d = wbin_d - rbin;
        full_d  = (gray_d == full_cmp);
        afull_d = (level_d >= PtrW'(AFULL_THRESH));

        // A blocked write sets the flag; set has priority over clear.
        ovf_d = ovf_q;
        if (w_inc && full_q) begin
            ovf_d = 1'b1;
        end else if (w_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            wbin_q  <= '0;
            gray_q  <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wbin_q  <= wbin_d;
            gray_q  <= gray_d;
            level_q <= level_d;
            full_q  <= full_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
        end
    end

    assign w_en        = accept;
    assign w_addr      = wbin_q[ADDR_W-1:0];
    assign gray_w_ptr  = gray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign w_level     = level_q;
    assign overflow    = ovf_q;

    // The Gray-compare full and the level-derived full must never disagree.
    a_full_forms_agree : assert property (
        @(posedge w_clk) disable iff (!w_rstn)
        full_d == (level_d == PtrW'(Depth))
    );

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_ctrl
// Self-checking bench for fifo_wr_ctrl with ADDR_W=3, AFULL_THRESH=6.
// Directed vector table for fill/overflow/release, hand sequences for reset
// behaviour, and a randomised phase against an occupancy-count model with a
// reader whose pointer reaches the write side two cycles late.
// -----------------------------------------------------------------------------
module tb_fifo_wr_ctrl;

    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;
    localparam int          AFT   = 6;

    logic          w_clk;
    logic          w_rstn;
    logic          w_inc;
    logic          w_clr_ovf;
    logic [AW:0]   sync_rd_ptr;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW:0]   gray_w_ptr;
    logic          full;
    logic          almost_full;
    logic [AW:0]   w_level;
    logic          overflow;

    int n_cmp;
    int n_fail;

    fifo_wr_ctrl #(
        .ADDR_W       (AW),
        .AFULL_THRESH (AFT)
    ) dut (
        .w_clk       (w_clk),
        .w_rstn      (w_rstn),
        .w_inc       (w_inc),
        .w_clr_ovf   (w_clr_ovf),
        .sync_rd_ptr (sync_rd_ptr),
        .w_en        (w_en),
        .w_addr      (w_addr),
        .gray_w_ptr  (gray_w_ptr),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    typedef struct {
        logic       inc;
        logic       clr;
        logic [3:0] rd;
        logic       en;    // expected before the edge
        logic [2:0] addr;  // expected before the edge
        logic [3:0] gray;  // expected after the edge
        logic       full;
        logic       af;
        logic [3:0] lvl;
        logic       ovf;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic inc, logic clr, logic [3:0] rd, logic en,
                                logic [2:0] addr, logic [3:0] gray, logic f,
                                logic af, logic [3:0] lvl, logic ovf);
        vec_t v;
        v.inc = inc; v.clr = clr; v.rd = rd; v.en = en; v.addr = addr;
        v.gray = gray; v.full = f; v.af = af; v.lvl = lvl; v.ovf = ovf;
        return v;
    endfunction

    function automatic int to_gray(int b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".w_addr"}, int'(w_addr), 0);
        chk({tag, ".gray"}, int'(gray_w_ptr), 0);
        chk({tag, ".full"}, int'(full), 0);
        chk({tag, ".afull"}, int'(almost_full), 0);
        chk({tag, ".level"}, int'(w_level), 0);
        chk({tag, ".ovf"}, int'(overflow), 0);
    endtask

    // Reset asserted half-way through a low clock phase, released on negedge.
    task automatic do_reset();
        @(negedge w_clk);
        #2;
        w_rstn = 1'b0;
        @(negedge w_clk);
        w_rstn = 1'b1;
        #1;
    endtask

    // Random-phase model state
    int wr_total, rd_total, rd_d1, rd_d2;
    int m_level;
    bit m_full, m_ovf;
    logic [3:0] prev_gray;

    initial begin
        n_cmp = 0;
        n_fail = 0;
        w_rstn = 1'b0;
        w_inc = 1'b0;
        w_clr_ovf = 1'b0;
        sync_rd_ptr = '0;

        // ---------------- reset state ----------------
        #3;
        chk_all_zero("rst");
        chk("rst.w_en", int'(w_en), 0);
        @(negedge w_clk);
        w_rstn = 1'b1;
        tick();
        tick();
        chk_all_zero("post_rst");
        chk("post_rst.w_en", int'(w_en), 0);

        // ---------------- directed table ----------------
        tbl[0]  = mk(1, 0, 4'b0000, 1, 3'd0, 4'b0001, 0, 0, 4'd1, 0);
        tbl[1]  = mk(1, 0, 4'b0000, 1, 3'd1, 4'b0011, 0, 0, 4'd2, 0);
        tbl[2]  = mk(1, 0, 4'b0000, 1, 3'd2, 4'b0010, 0, 0, 4'd3, 0);
        tbl[3]  = mk(1, 0, 4'b0000, 1, 3'd3, 4'b0110, 0, 0, 4'd4, 0);
        tbl[4]  = mk(1, 0, 4'b0000, 1, 3'd4, 4'b0111, 0, 0, 4'd5, 0);
        tbl[5]  = mk(1, 0, 4'b0000, 1, 3'd5, 4'b0101, 0, 1, 4'd6, 0);
        tbl[6]  = mk(1, 0, 4'b0000, 1, 3'd6, 4'b0100, 0, 1, 4'd7, 0);
        tbl[7]  = mk(1, 0, 4'b0000, 1, 3'd7, 4'b1100, 1, 1, 4'd8, 0);
        // Blocked writes at full set overflow and keep it set
        tbl[8]  = mk(1, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
        tbl[9]  = mk(1, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
        // Clear without a blocked write
        tbl[10] = mk(0, 1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 0);
        // Clear and blocked write together: set wins
        tbl[11] = mk(1, 1, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
        tbl[12] = mk(0, 0, 4'b0000, 0, 3'd0, 4'b1100, 1, 1, 4'd8, 1);
        // Reader shows one read: full drops, level 7
        tbl[13] = mk(0, 0, 4'b0001, 0, 3'd0, 4'b1100, 0, 1, 4'd7, 1);
        // Write into the freed slot refills
        tbl[14] = mk(1, 0, 4'b0001, 1, 3'd0, 4'b1101, 1, 1, 4'd8, 1);
        tbl[15] = mk(0, 1, 4'b0001, 0, 3'd1, 4'b1101, 1, 1, 4'd8, 0);

        for (int i = 0; i < 16; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            w_inc = tbl[i].inc;
            w_clr_ovf = tbl[i].clr;
            sync_rd_ptr = tbl[i].rd;
            #1;
            chk({nm, ".w_en"}, int'(w_en), int'(tbl[i].en));
            if (i != 15) chk({nm, ".w_addr"}, int'(w_addr), int'(tbl[i].addr));
            tick();
            chk({nm, ".gray"}, int'(gray_w_ptr), int'(tbl[i].gray));
            chk({nm, ".full"}, int'(full), int'(tbl[i].full));
            chk({nm, ".afull"}, int'(almost_full), int'(tbl[i].af));
            chk({nm, ".level"}, int'(w_level), int'(tbl[i].lvl));
            chk({nm, ".ovf"}, int'(overflow), int'(tbl[i].ovf));
        end
        chk("vec15.w_addr_after", int'(w_addr), 1);
        w_inc = 1'b0;
        w_clr_ovf = 1'b0;

        // ---------------- mid-operation reset ----------------
        do_reset();
        sync_rd_ptr = '0;
        for (int i = 0; i < 5; i++) begin
            w_inc = 1'b1;
            tick();
        end
        chk("mid.level5", int'(w_level), 5);
        // Hold w_inc high across the async reset
        @(negedge w_clk);
        #2;
        w_rstn = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        chk("mid_rst.w_en", int'(w_en), 1);
        @(negedge w_clk);
        w_inc = 1'b0;
        w_rstn = 1'b1;
        #1;
        w_inc = 1'b1;
        #1;
        chk("mid.first_addr", int'(w_addr), 0);
        chk("mid.first_en", int'(w_en), 1);
        tick();
        chk("mid.first_level", int'(w_level), 1);
        chk("mid.first_gray", int'(gray_w_ptr), 1);
        w_inc = 1'b0;

        // ---------------- randomised with lagging reader ----------------
        do_reset();
        wr_total = 0;
        rd_total = 0;
        rd_d1 = 0;
        rd_d2 = 0;
        m_full = 0;
        m_ovf = 0;
        prev_gray = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit inc, clr, acc;
            inc = ($urandom_range(0, 99) < 60);
            clr = ($urandom_range(0, 15) == 0);
            w_inc = inc;
            w_clr_ovf = clr;
            sync_rd_ptr = 4'(to_gray(rd_d2 % 16));
            acc = inc && !m_full;
            #1;
            chk("rnd.w_en", int'(w_en), int'(acc));
            chk("rnd.w_addr", int'(w_addr), wr_total % DEPTH);
            tick();
            if (acc) wr_total++;
            if (inc && m_full) m_ovf = 1;
            else if (clr) m_ovf = 0;
            m_level = wr_total - rd_d2;
            m_full = (m_level == DEPTH);
            chk("rnd.level", int'(w_level), m_level);
            chk("rnd.full", int'(full), int'(m_full));
            chk("rnd.afull", int'(almost_full), int'(m_level >= AFT));
            chk("rnd.ovf", int'(overflow), int'(m_ovf));
            chk("rnd.gray", int'(gray_w_ptr), to_gray(wr_total % 16));
            chk("rnd.gray_step", int'($countones(gray_w_ptr ^ prev_gray) <= 1), 1);
            chk("rnd.level_max", int'(w_level <= 4'd8), 1);
            chk("rnd.full_eq_level", int'(full), int'(w_level == 4'd8));
            prev_gray = gray_w_ptr;
            rd_d2 = rd_d1;
            rd_d1 = rd_total;
            if (rd_total < wr_total && $urandom_range(0, 99) < 50) rd_total++;
        end
        chk("rnd.laps", int'(wr_total >= 48), 1);
        w_inc = 1'b0;
        w_clr_ovf = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
